fft_frame_feeder: RTL and testbench

- Upstream stage of the 16-point FFT wrapper.
- Turns an arbitrary AXI-Stream sample stream into exact N-word frames: N consecutive valid beats, tkeep all ones, tlast on beat N-1.
- Absorbs upstream stalls, zero-pads short frames and truncates long ones.
- Launches a frame only when the FFT wrapper reports not-busy, because the wrapper neither stalls nor tolerates gaps inside a frame.

---
 rtl/fft_frame_feeder.sv | 169 ++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_feeder.sv
// Frame feeder for the FFT wrapper: buffers one input packet, pads or truncates it to N_WORDS
// and bursts it out gaplessly once the wrapper is idle. Optional stats counters: FEED_STATS_EN.
module fft_frame_feeder #(
    parameter int N_WORDS    = 16,
    parameter int DW         = 32,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DW-1:0]     s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic [DW/8-1:0]   s_axis_tkeep,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DW-1:0]     m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic [DW/8-1:0]   m_axis_tkeep,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    input  logic              dut_busy,
    output logic              frame_sent,
    output logic              err_trunc,
    output logic              err_stall,
    input  logic              err_clr
`ifdef FEED_STATS_EN
   ,output logic [15:0]       frames_cnt,
    output logic [15:0]       pad_cnt,
    output logic [15:0]       drop_cnt,
    input  logic              stats_clr
`endif
);
    localparam int AW = $clog2(N_WORDS);
    localparam int KW = DW / 8;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {FILL, DROP, WAIT, BURST, GAP} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]     fill_q, fill_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [DW-1:0]   buf_q [N_WORDS];
    logic [DW-1:0]   wdata;
    logic            acc, trunc_set, stall_set;
    logic            s_rdy_q, s_rdy_d, m_vld_q, m_vld_d, m_last_q, m_last_d, sent_q, sent_d;
    logic [DW-1:0]   m_data_q, m_data_d;
    logic            trunc_q, stall_q;

    for (genvar b = 0; b < KW; b++) begin : g_mask
        assign wdata[b*8 +: 8] = s_axis_tkeep[b] ? s_axis_tdata[b*8 +: 8] : 8'h00;
    end

    assign acc       = s_axis_tvalid & s_rdy_q;
    assign trunc_set = (state_q == FILL) && acc && !s_axis_tlast && (wr_q == AW'(N_WORDS - 1));
    assign stall_set = (state_q == BURST) && !m_axis_tready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= FILL;
            wr_q     <= '0;
            rd_q     <= '0;
            fill_q   <= '0;
            gap_q    <= '0;
            s_rdy_q  <= 1'b0;
            m_vld_q  <= 1'b0;
            m_last_q <= 1'b0;
            m_data_q <= '0;
            sent_q   <= 1'b0;
            trunc_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            fill_q   <= fill_d;
            gap_q    <= gap_d;
            s_rdy_q  <= s_rdy_d;
            m_vld_q  <= m_vld_d;
            m_last_q <= m_last_d;
            m_data_q <= m_data_d;
            sent_q   <= sent_d;
            trunc_q  <= err_clr ? 1'b0 : (trunc_q | trunc_set);
            stall_q  <= err_clr ? 1'b0 : (stall_q | stall_set);
        end
    end

    // Stale entries beyond fill_q are never read, so the buffer needs no reset.
    always_ff @(posedge clk) begin
        if (acc && state_q == FILL) buf_q[wr_q] <= wdata;
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        fill_d  = fill_q;
        gap_d   = gap_q;
        unique case (state_q)
            FILL: if (acc) begin
                wr_d   = wr_q + 1'b1;
                fill_d = {1'b0, wr_q} + 1'b1;
                if (s_axis_tlast)                    state_d = WAIT;
                else if (wr_q == AW'(N_WORDS - 1))   state_d = DROP;
            end
            DROP: if (acc && s_axis_tlast) state_d = WAIT;
            WAIT: if (!dut_busy && m_axis_tready) begin
                state_d = BURST;
                rd_d    = '0;
            end
            BURST: if (rd_q == AW'(N_WORDS - 1)) begin
                state_d = GAP;
                gap_d   = '0;
            end else begin
                rd_d = rd_q + 1'b1;
            end
            GAP: if (gap_q == GW'(GAP_CYCLES - 1)) begin
                state_d = FILL;
                wr_d    = '0;
                fill_d  = '0;
            end else begin
                gap_d = gap_q + 1'b1;
            end
            default: state_d = FILL;
        endcase
    end

    // Outputs are registered from the next state so the beat lines up with rd_d.
    always_comb begin
        s_rdy_d  = (state_d == FILL) || (state_d == DROP);
        m_vld_d  = (state_d == BURST);
        m_last_d = m_vld_d && (rd_d == AW'(N_WORDS - 1));
        m_data_d = (m_vld_d && ({1'b0, rd_d} < fill_q)) ? buf_q[rd_d] : '0;
        sent_d   = (state_q == BURST) && (state_d == GAP);
    end

    assign s_axis_tready = s_rdy_q;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = '1;
    assign frame_sent    = sent_q;
    assign err_trunc     = trunc_q;
    assign err_stall     = stall_q;

`ifdef FEED_STATS_EN
    logic [15:0] frames_q, pad_q, drop_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frames_q <= '0;
            pad_q    <= '0;
            drop_q   <= '0;
        end else if (stats_clr) begin
            frames_q <= '0;
            pad_q    <= '0;
            drop_q   <= '0;
        end else begin
            if (sent_q) frames_q <= frames_q + 1'b1;
            if (state_q == FILL && state_d == WAIT && fill_d < (AW+1)'(N_WORDS)) pad_q <= pad_q + 1'b1;
            if (state_q == DROP && acc) drop_q <= drop_q + 1'b1;
        end
    end

    assign frames_cnt = frames_q;
    assign pad_cnt    = pad_q;
    assign drop_cnt   = drop_q;
`endif

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: table of packet lengths plus hand sequences for
// busy hold-off, tkeep masking with input gaps, downstream stall and mid-burst reset.
module tb_fft_frame_feeder;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic [3:0]  s_axis_tkeep = '1;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        dut_busy = 1'b0;
    logic        frame_sent, err_trunc, err_stall;
    logic        err_clr = 1'b0;
`ifdef FEED_STATS_EN
    logic [15:0] frames_cnt, pad_cnt, drop_cnt;
    logic        stats_clr = 1'b0;
`endif

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fft_frame_feeder #(.N_WORDS(N), .DW(32), .GAP_CYCLES(2)) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .dut_busy(dut_busy), .frame_sent(frame_sent),
        .err_trunc(err_trunc), .err_stall(err_stall), .err_clr(err_clr)
`ifdef FEED_STATS_EN
       ,.frames_cnt(frames_cnt), .pad_cnt(pad_cnt), .drop_cnt(drop_cnt), .stats_clr(stats_clr)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int w = 0;
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
        while (!s_axis_tready && w < 200) begin tick(); w++; end
        if (w >= 200) begin
            nchk++; nerr++;
            $display("FAIL send_timeout: tready got 0 expected 1");
        end
        tick();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tkeep = '1;
    endtask

    // Consumes one frame; optional single-cycle downstream stall at beat stall_at.
    task automatic recv(input string nm, input logic [31:0] exp [N], input int stall_at, output int lat);
        lat = 0;
        while (!m_axis_tvalid && lat < 200) begin tick(); lat++; end
        chk({nm, " tkeep"}, 32'(m_axis_tkeep), 32'hF);
        for (int b = 0; b < N; b++) begin
            chk($sformatf("%s[%0d] valid", nm, b), 32'(m_axis_tvalid), 32'd1);
            chk($sformatf("%s[%0d] data", nm, b), m_axis_tdata, exp[b]);
            chk($sformatf("%s[%0d] last", nm, b), 32'(m_axis_tlast), 32'(b == N - 1));
            m_axis_tready = (b != stall_at);
            tick();
            m_axis_tready = 1'b1;
        end
        chk({nm, " post valid"}, 32'(m_axis_tvalid), 32'd0);
        chk({nm, " post data"}, m_axis_tdata, 32'd0);
        chk({nm, " post last"}, 32'(m_axis_tlast), 32'd0);
        chk({nm, " frame_sent"}, 32'(frame_sent), 32'd1);
        chk({nm, " gap tready"}, 32'(s_axis_tready), 32'd0);
        tick();
        chk({nm, " frame_sent pulse"}, 32'(frame_sent), 32'd0);
    endtask

    typedef struct {
        int          nin;
        logic [31:0] base;
        int          nvalid;
        logic        trunc;
    } vec_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [5];
        logic [31:0] exp [N];
        int          lat, bad;
        logic [31:0] dseq [4];
        logic [3:0]  kseq [4];

        vecs[0] = '{16, 32'h0000_0001, 16, 1'b0};
        vecs[1] = '{5,  32'h0000_00A0, 5,  1'b0};
        vecs[2] = '{20, 32'h0000_0000, 16, 1'b1};
        vecs[3] = '{1,  32'h0000_0055, 1,  1'b0};
        vecs[4] = '{17, 32'h0000_0100, 16, 1'b1};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst tdata", m_axis_tdata, 32'd0);
        chk("rst tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst tkeep", 32'(m_axis_tkeep), 32'hF);
        chk("rst s_tready", 32'(s_axis_tready), 32'd0);
        chk("rst frame_sent", 32'(frame_sent), 32'd0);
        chk("rst errs", {30'd0, err_trunc, err_stall}, 32'd0);
        rstn = 1'b1;
        tick();
        chk("post-rst s_tready", 32'(s_axis_tready), 32'd1);

        foreach (vecs[v]) begin
            for (int i = 0; i < vecs[v].nin; i++)
                send_beat(vecs[v].base + 32'(i), 4'hF, i == vecs[v].nin - 1);
            chk($sformatf("v%0d wait valid", v), 32'(m_axis_tvalid), 32'd0);
            for (int b = 0; b < N; b++)
                exp[b] = (b < vecs[v].nvalid) ? vecs[v].base + 32'(b) : 32'd0;
            recv($sformatf("v%0d", v), exp, -1, lat);
            chk($sformatf("v%0d latency", v), 32'(lat), 32'd1);
            chk($sformatf("v%0d err_trunc", v), 32'(err_trunc), 32'(vecs[v].trunc));
            err_clr = 1'b1; tick(); err_clr = 1'b0;
            chk($sformatf("v%0d err_clr", v), 32'(err_trunc), 32'd0);
        end
`ifdef FEED_STATS_EN
        chk("frames_cnt", 32'(frames_cnt), 32'd5);
        chk("pad_cnt", 32'(pad_cnt), 32'd2);
        chk("drop_cnt", 32'(drop_cnt), 32'd5);
        stats_clr = 1'b1; tick(); stats_clr = 1'b0;
        chk("stats_clr", {frames_cnt, pad_cnt | drop_cnt}, 32'd0);
`endif

        // Busy hold-off: filled frame must wait for dut_busy to drop
        dut_busy = 1'b1;
        for (int i = 0; i < N; i++) send_beat(32'h500 + 32'(i), 4'hF, i == N - 1);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (m_axis_tvalid || s_axis_tready) bad++;
        end
        chk("busy hold cycles", 32'(bad), 32'd0);
        dut_busy = 1'b0;
        for (int b = 0; b < N; b++) exp[b] = 32'h500 + 32'(b);
        recv("busy", exp, -1, lat);
        chk("busy release latency", 32'(lat), 32'd1);

        // tkeep masking with input gaps; tlast without tvalid must be ignored
        dseq = '{32'h10, 32'hDEADBEEF, 32'h12, 32'h13};
        kseq = '{4'hF, 4'h3, 4'hF, 4'hF};
        for (int i = 0; i < 4; i++) begin
            send_beat(dseq[i], kseq[i], i == 3);
            if (i < 3) begin
                s_axis_tlast = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                s_axis_tlast = 1'b0;
            end
        end
        exp = '{default: 32'd0};
        exp[0] = 32'h10; exp[1] = 32'h0000BEEF; exp[2] = 32'h12; exp[3] = 32'h13;
        recv("keep", exp, -1, lat);
        chk("keep no trunc", 32'(err_trunc), 32'd0);

        // Downstream stall mid-burst: frame still gapless, sticky err_stall set
        for (int i = 0; i < N; i++) send_beat(32'h600 + 32'(i), 4'hF, i == N - 1);
        for (int b = 0; b < N; b++) exp[b] = 32'h600 + 32'(b);
        recv("stall", exp, 5, lat);
        chk("err_stall set", 32'(err_stall), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("err_stall clr", 32'(err_stall), 32'd0);

        // Reset on burst beat 7
        for (int i = 0; i < N; i++) send_beat(32'h700 + 32'(i), 4'hF, i == N - 1);
        lat = 0;
        while (!m_axis_tvalid && lat < 200) begin tick(); lat++; end
        repeat (6) tick();
        chk("pre-rst beat7", m_axis_tdata, 32'h706);
        rstn = 1'b0;
        #1;
        chk("midrst tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst tdata", m_axis_tdata, 32'd0);
        chk("midrst tlast", 32'(m_axis_tlast), 32'd0);
        chk("midrst s_tready", 32'(s_axis_tready), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("after rst s_tready", 32'(s_axis_tready), 32'd1);
        for (int i = 0; i < N; i++) send_beat(32'h800 + 32'(i), 4'hF, i == N - 1);
        for (int b = 0; b < N; b++) exp[b] = 32'h800 + 32'(b);
        recv("postrst", exp, -1, lat);
        chk("postrst latency", 32'(lat), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
